// File: rtl/mem_arbiter_if.sv
// Client request/acknowledge and memory strobe signals of mem_arbiter.
// Latency: none, this file holds only wires.
// Backpressure: clients hold Req until Ack. The memory never stalls.
//
// Ports (parameters AddrSize, DataSize):
//   Req0/Req1, RW0/RW1, Addr0/Addr1, Din0/Din1   client request side
//   Ack0/Ack1, RdData, RdValid                   completion back to clients
//   Mem_Valid, Mem_R_W, Mem_Addr, Mem_Din        strobe to the memory
//   Mem_Dout                                     registered read data from the memory
// The slave modport is the arbiter's view. The master modport is the
// surrounding clients plus the memory.
interface mem_arbiter_if #(
    parameter int AddrSize = 8,
    parameter int DataSize = 32
);
    logic                Req0;
    logic                Req1;
    logic                RW0;
    logic                RW1;
    logic [AddrSize-1:0] Addr0;
    logic [AddrSize-1:0] Addr1;
    logic [DataSize-1:0] Din0;
    logic [DataSize-1:0] Din1;
    logic                Ack0;
    logic                Ack1;
    logic [DataSize-1:0] RdData;
    logic                RdValid;
    logic                Mem_Valid;
    logic                Mem_R_W;
    logic [AddrSize-1:0] Mem_Addr;
    logic [DataSize-1:0] Mem_Din;
    logic [DataSize-1:0] Mem_Dout;

    modport slave (
        input  Req0, Req1, RW0, RW1, Addr0, Addr1, Din0, Din1, Mem_Dout,
        output Ack0, Ack1, RdData, RdValid, Mem_Valid, Mem_R_W, Mem_Addr, Mem_Din
    );

    modport master (
        output Req0, Req1, RW0, RW1, Addr0, Addr1, Din0, Din1, Mem_Dout,
        input  Ack0, Ack1, RdData, RdValid, Mem_Valid, Mem_R_W, Mem_Addr, Mem_Din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter that serialises requests onto one single-port memory.
// Latency: Req sampled in IDLE at cycle t gives Mem_Valid in t+1 and Ack/RdValid/RdData in t+3.
// Backpressure: requests wait, held high, until acked. One access every 4 cycles.
//
// Ports: Clk (rising edge), Reset (synchronous, active-high), bus (mem_arbiter_if.slave).
// Optional macro MEM_ARB_FIXED_PRIO_EN selects fixed priority, where requester 0
// always wins contention. When it is undefined, the arbiter alternates winners
// under contention.
module mem_arbiter #(
    parameter int AddrSize = 8,
    parameter int DataSize = 32
) (
    input logic          Clk,
    input logic          Reset,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0]          state_q,     state_d;
    logic                gnt_q,       gnt_d;
    logic                ack0_q,      ack0_d;
    logic                ack1_q,      ack1_d;
    logic                rd_valid_q,  rd_valid_d;
    logic [DataSize-1:0] rd_data_q,   rd_data_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_r_w_q,   mem_r_w_d;
    logic [AddrSize-1:0] mem_addr_q,  mem_addr_d;
    logic [DataSize-1:0] mem_din_q,   mem_din_d;
    logic                win;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
    logic                last_gnt_q,  last_gnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rd_data_d   = rd_data_q;
        mem_r_w_d   = mem_r_w_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        // The strobe and the completion flags are single-cycle pulses, so they default low.
        mem_valid_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rd_valid_d  = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        win         = ~bus.Req0;
`else
        last_gnt_d  = last_gnt_q;
        // When both requesters are high, the winner is the one that was not granted last time.
        win         = (bus.Req0 & bus.Req1) ? ~last_gnt_q : bus.Req1;
`endif

        case (state_q)
            IDLE: begin
                if (bus.Req0 | bus.Req1) begin
                    gnt_d       = win;
                    mem_r_w_d   = win ? bus.RW1   : bus.RW0;
                    mem_addr_d  = win ? bus.Addr1 : bus.Addr0;
                    mem_din_d   = win ? bus.Din1  : bus.Din0;
                    mem_valid_d = 1'b1;
                    state_d     = ACCESS;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
                    last_gnt_d  = win;
`endif
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // The memory registered its read data at the end of ACCESS.
                if (!mem_r_w_q) begin
                    rd_data_d = bus.Mem_Dout;
                end
                ack0_d     = ~gnt_q;
                ack1_d     = gnt_q;
                rd_valid_d = ~mem_r_w_q;
                state_d    = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_r_w_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            // Requester 0 wins the first contention after reset.
            last_gnt_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            mem_valid_q <= mem_valid_d;
            mem_r_w_q   <= mem_r_w_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            last_gnt_q  <= last_gnt_d;
`endif
        end
    end

    assign bus.Ack0      = ack0_q;
    assign bus.Ack1      = ack1_q;
    assign bus.RdValid   = rd_valid_q;
    assign bus.RdData    = rd_data_q;
    assign bus.Mem_Valid = mem_valid_q;
    assign bus.Mem_R_W   = mem_r_w_q;
    assign bus.Mem_Addr  = mem_addr_q;
    assign bus.Mem_Din   = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomised run against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: requesters hold Req until Ack and drop it right after.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AddrSize(8), .DataSize(32)) bus();
    mem_arbiter #(.AddrSize(8), .DataSize(32)) dut (.Clk(clk), .Reset(rst), .bus(bus));

    // Single-port memory: writes on the strobe, read data registered one cycle after a read strobe.
    logic [31:0] mem [256];
    logic [31:0] mem_dout = 32'h0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (bus.Mem_Valid === 1'b1) begin
            if (bus.Mem_R_W) mem[bus.Mem_Addr] <= bus.Mem_Din;
            else             mem_dout <= mem[bus.Mem_Addr];
        end
    end
    assign bus.Mem_Dout = mem_dout;

    // Reference memory contents, updated by the bench when it expects a write.
    logic [31:0] ref_mem [256];

    // Properties that must hold on every cycle.
    logic prev_mv = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((bus.Ack0 & bus.Ack1) !== 1'b0) begin
                failures++;
                $display("FAIL ack_exclusive t=%0t Ack0=%b Ack1=%b required not both", $time, bus.Ack0, bus.Ack1);
            end
            checks++;
            if ((prev_mv & bus.Mem_Valid) !== 1'b0) begin
                failures++;
                $display("FAIL mem_valid_single t=%0t two consecutive strobes", $time);
            end
        end
        prev_mv = bus.Mem_Valid;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.Req0 = 0; bus.Req1 = 0; bus.RW0 = 0; bus.RW1 = 0;
        bus.Addr0 = 0; bus.Addr1 = 0; bus.Din0 = 0; bus.Din1 = 0;
    endtask

    // Ends at a negedge where the arbiter is in IDLE and Reset is low.
    task automatic do_reset();
        drive_idle();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic set_req(input int who, input logic on, input logic rw,
                           input logic [7:0] a, input logic [31:0] d);
        if (who == 0) begin bus.Req0 = on; bus.RW0 = rw; bus.Addr0 = a; bus.Din0 = d; end
        else          begin bus.Req1 = on; bus.RW1 = rw; bus.Addr1 = a; bus.Din1 = d; end
    endtask

    // Issues one request from the current IDLE cycle and observes it, without judging it.
    task automatic run_txn(input int who, input logic rw, input logic [7:0] a, input logic [31:0] d,
                           output int ack_lat, output int mv_lat, output logic [7:0] mv_addr,
                           output logic rdv, output logic [31:0] rdd);
        ack_lat = -1; mv_lat = -1; mv_addr = 0; rdv = 0; rdd = 0;
        set_req(who, 1, rw, a, d);
        for (int k = 1; k <= 12 && ack_lat < 0; k++) begin
            @(negedge clk);
            if (bus.Mem_Valid === 1'b1 && mv_lat < 0) begin mv_lat = k; mv_addr = bus.Mem_Addr; end
            if (((who == 0) ? bus.Ack0 : bus.Ack1) === 1'b1) begin
                ack_lat = k; rdv = bus.RdValid; rdd = bus.RdData;
            end
        end
        set_req(who, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        repeat (2) @(negedge clk);
        checks++; if (bus.Ack0 !== 1'b0)      begin failures++; $display("FAIL rst_ack0 got=%b exp=0", bus.Ack0); end
        checks++; if (bus.Ack1 !== 1'b0)      begin failures++; $display("FAIL rst_ack1 got=%b exp=0", bus.Ack1); end
        checks++; if (bus.RdValid !== 1'b0)   begin failures++; $display("FAIL rst_rdvalid got=%b exp=0", bus.RdValid); end
        checks++; if (bus.Mem_Valid !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%b exp=0", bus.Mem_Valid); end
        checks++; if (bus.Mem_R_W !== 1'b0)   begin failures++; $display("FAIL rst_mem_rw got=%b exp=0", bus.Mem_R_W); end
        checks++; if (bus.Mem_Addr !== 8'h0)  begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", bus.Mem_Addr); end
        checks++; if (bus.Mem_Din !== 32'h0)  begin failures++; $display("FAIL rst_mem_din got=%h exp=0", bus.Mem_Din); end
        checks++; if (bus.RdData !== 32'h0)   begin failures++; $display("FAIL rst_rddata got=%h exp=0", bus.RdData); end
        mem_clr = 0;
        rst = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        mon_en = 1;
    endtask

    task automatic test_write_read();
        int al, ml; logic [7:0] ma; logic rv; logic [31:0] rd;
        run_txn(0, 1, 8'h05, 32'hDEADBEEF, al, ml, ma, rv, rd);
        ref_mem[8'h05] = 32'hDEADBEEF;
        checks++; if (ml !== 1)     begin failures++; $display("FAIL wr_strobe_lat got=%0d exp=1", ml); end
        checks++; if (ma !== 8'h05) begin failures++; $display("FAIL wr_strobe_addr got=%h exp=05", ma); end
        checks++; if (al !== 3)     begin failures++; $display("FAIL wr_ack_lat got=%0d exp=3", al); end
        checks++; if (rv !== 1'b0)  begin failures++; $display("FAIL wr_rdvalid got=%b exp=0", rv); end
        run_txn(1, 0, 8'h05, 32'h0, al, ml, ma, rv, rd);
        checks++; if (al !== 3)            begin failures++; $display("FAIL rd_ack_lat got=%0d exp=3", al); end
        checks++; if (rv !== 1'b1)         begin failures++; $display("FAIL rd_rdvalid got=%b exp=1", rv); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_contention();
        logic e0, e1;
        do_reset();
        set_req(0, 1, 0, 8'h01, 32'h0);
        set_req(1, 1, 0, 8'h02, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
            e0 = (c % 4 == 3); e1 = 1'b0;
`else
            e0 = (c % 8 == 3); e1 = (c % 8 == 7);
`endif
            checks++; if (bus.Ack0 !== e0) begin failures++; $display("FAIL cont_ack0 cyc=%0d got=%b exp=%b", c, bus.Ack0, e0); end
            checks++; if (bus.Ack1 !== e1) begin failures++; $display("FAIL cont_ack1 cyc=%0d got=%b exp=%b", c, bus.Ack1, e1); end
        end
        drive_idle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_in_capture();
        int al, ml; logic [7:0] ma; logic rv; logic [31:0] rd;
        do_reset();
        run_txn(0, 1, 8'h05, 32'h12345678, al, ml, ma, rv, rd);
        ref_mem[8'h05] = 32'h12345678;
        set_req(0, 1, 0, 8'h05, 32'hA5A5A5A5);
        repeat (2) @(negedge clk);   // arbiter is now in CAPTURE
        rst = 1; drive_idle();
        @(negedge clk);
        rst = 0;
        checks++; if (bus.Ack0 !== 1'b0)      begin failures++; $display("FAIL rcap_ack0 got=%b exp=0", bus.Ack0); end
        checks++; if (bus.RdValid !== 1'b0)   begin failures++; $display("FAIL rcap_rdvalid got=%b exp=0", bus.RdValid); end
        checks++; if (bus.RdData !== 32'h0)   begin failures++; $display("FAIL rcap_rddata got=%h exp=0", bus.RdData); end
        checks++; if (bus.Mem_Addr !== 8'h0)  begin failures++; $display("FAIL rcap_mem_addr got=%h exp=0", bus.Mem_Addr); end
        checks++; if (bus.Mem_Din !== 32'h0)  begin failures++; $display("FAIL rcap_mem_din got=%h exp=0", bus.Mem_Din); end
        checks++; if (bus.Mem_Valid !== 1'b0) begin failures++; $display("FAIL rcap_mem_valid got=%b exp=0", bus.Mem_Valid); end
        run_txn(1, 0, 8'h05, 32'h0, al, ml, ma, rv, rd);
        checks++; if (al !== 3)            begin failures++; $display("FAIL rcap_next_ack got=%0d exp=3", al); end
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL rcap_next_data got=%h exp=12345678", rd); end
    endtask

    task automatic test_held_req();
        logic [31:0] d;
        logic [7:0] exp_mv, exp_ack, got_mv, got_ack;
        d = $urandom;
        exp_mv  = 8'b0010_0010;   // strobes at t+1 and t+5 (bit k = cycle t+k)
        exp_ack = 8'b1000_1000;   // acks at t+3 and t+7
        got_mv = 0; got_ack = 0;
        set_req(0, 1, 1, 8'h10, d);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            got_mv[k]  = bus.Mem_Valid;
            got_ack[k] = bus.Ack0;
            if (k == 5) drive_idle();
        end
        @(negedge clk);
        ref_mem[8'h10] = d;
        checks++; if (got_mv !== exp_mv)   begin failures++; $display("FAIL held_strobes got=%b exp=%b", got_mv, exp_mv); end
        checks++; if (got_ack !== exp_ack) begin failures++; $display("FAIL held_acks got=%b exp=%b", got_ack, exp_ack); end
    endtask

    task automatic test_boundary_addr();
        int al, ml; logic [7:0] ma; logic rv; logic [31:0] rd, d;
        d = $urandom;
        run_txn(1, 1, 8'hFF, d, al, ml, ma, rv, rd);
        ref_mem[8'hFF] = d;
        checks++; if (ma !== 8'hFF) begin failures++; $display("FAIL top_strobe_addr got=%h exp=ff", ma); end
        run_txn(0, 0, 8'hFF, 32'h0, al, ml, ma, rv, rd);
        checks++; if (rd !== ref_mem[8'hFF]) begin failures++; $display("FAIL top_read got=%h exp=%h", rd, ref_mem[8'hFF]); end
        run_txn(1, 0, 8'h00, 32'h0, al, ml, ma, rv, rd);
        checks++; if (rd !== ref_mem[8'h00]) begin failures++; $display("FAIL zero_read got=%h exp=%h", rd, ref_mem[8'h00]); end
        checks++; if (rv !== 1'b1)           begin failures++; $display("FAIL zero_rdvalid got=%b exp=1", rv); end
    endtask

    // Random traffic. The model works per transaction: a grant at cycle g gives a
    // strobe at g+1, an ack at g+3, and the next grant opportunity at g+4.
    task automatic test_random();
        logic        pend[2], rrw[2], blocked[2];
        logic [7:0]  ra[2];
        logic [31:0] rdin[2];
        int          raise_c[2];
        int          last, free_at, g, gw, w, waited;
        logic        grw, e_mv, e_a0, e_a1, e_rv;
        logic [7:0]  gaddr;
        logic [31:0] gdin, gexp, exp_rd;
        do_reset();
        last = 1; free_at = 0; g = -100; gw = 0; grw = 0; gaddr = 0; gdin = 0; gexp = 0; exp_rd = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; rrw[i] = 0; ra[i] = 0; rdin[i] = 0; raise_c[i] = 0; blocked[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            e_mv = (c == g + 1);
            e_a0 = (c == g + 3) && (gw == 0);
            e_a1 = (c == g + 3) && (gw == 1);
            e_rv = (c == g + 3) && !grw;
            if (e_rv) exp_rd = gexp;
            checks++; if (bus.Mem_Valid !== e_mv) begin failures++; $display("FAIL rnd_mem_valid cyc=%0d got=%b exp=%b", c, bus.Mem_Valid, e_mv); end
            checks++; if (bus.Ack0 !== e_a0)      begin failures++; $display("FAIL rnd_ack0 cyc=%0d got=%b exp=%b", c, bus.Ack0, e_a0); end
            checks++; if (bus.Ack1 !== e_a1)      begin failures++; $display("FAIL rnd_ack1 cyc=%0d got=%b exp=%b", c, bus.Ack1, e_a1); end
            checks++; if (bus.RdValid !== e_rv)   begin failures++; $display("FAIL rnd_rdvalid cyc=%0d got=%b exp=%b", c, bus.RdValid, e_rv); end
            checks++; if (bus.RdData !== exp_rd)  begin failures++; $display("FAIL rnd_rddata cyc=%0d got=%h exp=%h", c, bus.RdData, exp_rd); end
            checks++; if (bus.Mem_Addr !== gaddr) begin failures++; $display("FAIL rnd_mem_addr cyc=%0d got=%h exp=%h", c, bus.Mem_Addr, gaddr); end
            checks++; if (bus.Mem_R_W !== grw)    begin failures++; $display("FAIL rnd_mem_rw cyc=%0d got=%b exp=%b", c, bus.Mem_R_W, grw); end
            checks++; if (bus.Mem_Din !== gdin)   begin failures++; $display("FAIL rnd_mem_din cyc=%0d got=%h exp=%h", c, bus.Mem_Din, gdin); end
            // Requesters drop on their ack and stay low for that cycle.
            for (int i = 0; i < 2; i++) begin
                blocked[i] = 0;
                if (pend[i] && c == g + 3 && gw == i) begin
                    pend[i] = 0; blocked[i] = 1;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    waited = c - raise_c[i];
                    checks++;
                    if (waited > 8) begin failures++; $display("FAIL rnd_wait req=%0d got=%0d exp<=8", i, waited); end
`endif
                end
                if (!pend[i] && !blocked[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1; rrw[i] = $urandom_range(0, 1);
                    ra[i] = $urandom_range(0, 7); rdin[i] = $urandom; raise_c[i] = c;
                end
                set_req(i, pend[i], rrw[i], ra[i], rdin[i]);
            end
            if (c == free_at) begin
                if (pend[0] || pend[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    w = pend[0] ? 0 : 1;
`else
                    w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
`endif
                    last = w; g = c; gw = w;
                    grw = rrw[w]; gaddr = ra[w]; gdin = rdin[w];
                    if (grw) ref_mem[gaddr] = gdin;
                    else     gexp = ref_mem[gaddr];
                    free_at = c + 4;
                end else begin
                    free_at = c + 1;
                end
            end
        end
        drive_idle();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_write_read();
        test_contention();
        test_reset_in_capture();
        test_held_req();
        test_boundary_addr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
